// File: rtl/decode_stage_pipe_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// decode_stage_pipe_if: IF->decode push, flush, and decode->EX control bundle
// Revision: 1.0
// ----------------------------------------------------------------------------
interface decode_stage_pipe_if #(
  parameter int INSTR_W    = 32,
  parameter int ALU_CODE_W = 5
);
  logic                  if_valid;
  logic                  if_ready;
  logic [INSTR_W-1:0]    if_instr;
  logic [INSTR_W-1:0]    if_pc;
  logic                  flush;
  logic                  ex_ready;
  logic                  id_valid;
  logic [INSTR_W-1:0]    id_pc;
  logic [INSTR_W-1:0]    id_instr;
  logic                  MemtoReg, RegWrite, MemWrite, MemRead, ALUSrcA;
  logic                  ALUSrcB, RegDst, J, JR, Branch;
  logic [ALU_CODE_W-1:0] ALUCode;

  modport master (
    input  if_valid, if_instr, if_pc, flush, ex_ready,
    output if_ready, id_valid, id_pc, id_instr,
    output MemtoReg, RegWrite, MemWrite, MemRead, ALUSrcA,
    output ALUSrcB, RegDst, J, JR, Branch, ALUCode
  );

  modport slave (
    output if_valid, if_instr, if_pc, flush, ex_ready,
    input  if_ready, id_valid, id_pc, id_instr,
    input  MemtoReg, RegWrite, MemWrite, MemRead, ALUSrcA,
    input  ALUSrcB, RegDst, J, JR, Branch, ALUCode
  );
endinterface
`default_nettype wire

// File: rtl/decode_stage_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// decode_stage_pipe: queued, registered MIPS decode with load-use bubble
// Revision: 1.0
// ----------------------------------------------------------------------------
module decode_stage_pipe #(
  parameter int INSTR_W     = 32,
  parameter int ALU_CODE_W  = 5,
  parameter int QDEPTH      = 2,
  parameter int LOAD_USE_EN = 1
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  decode_stage_pipe_if.master bus
);
  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int PW = AW + 1;

  localparam logic [ALU_CODE_W-1:0]
    ALU_ADD  = ALU_CODE_W'(0),  ALU_AND  = ALU_CODE_W'(1),  ALU_XOR  = ALU_CODE_W'(2),
    ALU_OR   = ALU_CODE_W'(3),  ALU_NOR  = ALU_CODE_W'(4),  ALU_SUB  = ALU_CODE_W'(5),
    ALU_ANDI = ALU_CODE_W'(6),  ALU_XORI = ALU_CODE_W'(7),  ALU_ORI  = ALU_CODE_W'(8),
    ALU_JR   = ALU_CODE_W'(9),  ALU_BEQ  = ALU_CODE_W'(10), ALU_BNE  = ALU_CODE_W'(11),
    ALU_BGEZ = ALU_CODE_W'(12), ALU_BGTZ = ALU_CODE_W'(13), ALU_BLEZ = ALU_CODE_W'(14),
    ALU_BLTZ = ALU_CODE_W'(15), ALU_SLL  = ALU_CODE_W'(16), ALU_SRL  = ALU_CODE_W'(17),
    ALU_SRA  = ALU_CODE_W'(18), ALU_SLT  = ALU_CODE_W'(19), ALU_SLTU = ALU_CODE_W'(20);

  typedef enum logic [0:0] {S_RUN = 1'b0, S_BUBBLE = 1'b1} state_t;

  state_t                state_q;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [2*INSTR_W-1:0]  mem_q [QDEPTH];
  logic                  id_valid_q;
  logic [INSTR_W-1:0]    id_pc_q, id_instr_q;
  logic [9:0]            ctrl_q;
  logic [ALU_CODE_W-1:0] alu_q;

  logic                  empty, full, avail, advance, hazard, push, pop;
  logic [INSTR_W-1:0]    head_instr, head_pc;
  logic [5:0]            op, funct;
  logic [4:0]            head_rs, head_rt, id_rt;
  logic                  d_mtr, d_rw, d_mw, d_mr, d_sa, d_sb, d_rd, d_j, d_jr, d_br;
  logic                  reads_rt, rtype_wr;
  logic [ALU_CODE_W-1:0] d_alu;
  logic [9:0]            dec_ctrl;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // An empty queue bypasses the incoming instruction straight to decode.
  assign {head_instr, head_pc} = empty ? {bus.if_instr, bus.if_pc} : mem_q[rd_ptr_q[AW-1:0]];
  assign avail = !empty || (bus.if_valid && !bus.flush);

  assign op      = head_instr[31:26];
  assign funct   = head_instr[5:0];
  assign head_rs = head_instr[25:21];
  assign head_rt = head_instr[20:16];
  assign id_rt   = id_instr_q[20:16];

  always_comb begin
    {d_mtr, d_rw, d_mw, d_mr, d_sa, d_sb, d_rd, d_j, d_jr, d_br} = '0;
    d_alu    = ALU_ADD;
    reads_rt = 1'b0;
    rtype_wr = 1'b0;
    if (head_instr != '0) begin
      case (op)
        6'h00: begin
          reads_rt = 1'b1;
          rtype_wr = 1'b1;
          case (funct)
            6'h00: begin d_alu = ALU_SLL; d_sa = 1'b1; end
            6'h02: begin d_alu = ALU_SRL; d_sa = 1'b1; end
            6'h03: begin d_alu = ALU_SRA; d_sa = 1'b1; end
            6'h04: d_alu = ALU_SLL;
            6'h06: d_alu = ALU_SRL;
            6'h07: d_alu = ALU_SRA;
            6'h08: begin rtype_wr = 1'b0; d_jr = 1'b1; d_alu = ALU_JR; end
            6'h20, 6'h21: d_alu = ALU_ADD;
            6'h22, 6'h23: d_alu = ALU_SUB;
            6'h24: d_alu = ALU_AND;
            6'h25: d_alu = ALU_OR;
            6'h26: d_alu = ALU_XOR;
            6'h27: d_alu = ALU_NOR;
            6'h2A: d_alu = ALU_SLT;
            6'h2B: d_alu = ALU_SLTU;
            default: rtype_wr = 1'b0;
          endcase
          d_rw = rtype_wr;
          d_rd = rtype_wr;
        end
        6'h01: begin
          if (head_rt == 5'd0) begin d_br = 1'b1; d_alu = ALU_BLTZ; end
          else if (head_rt == 5'd1) begin d_br = 1'b1; d_alu = ALU_BGEZ; end
        end
        6'h02: d_j = 1'b1;
        6'h04: begin d_br = 1'b1; d_alu = ALU_BEQ; reads_rt = 1'b1; end
        6'h05: begin d_br = 1'b1; d_alu = ALU_BNE; reads_rt = 1'b1; end
        6'h06: begin d_br = 1'b1; d_alu = ALU_BLEZ; end
        6'h07: begin d_br = 1'b1; d_alu = ALU_BGTZ; end
        6'h08, 6'h09: begin d_rw = 1'b1; d_sb = 1'b1; end
        6'h0A: begin d_rw = 1'b1; d_sb = 1'b1; d_alu = ALU_SLT;  end
        6'h0B: begin d_rw = 1'b1; d_sb = 1'b1; d_alu = ALU_SLTU; end
        6'h0C: begin d_rw = 1'b1; d_sb = 1'b1; d_alu = ALU_ANDI; end
        6'h0D: begin d_rw = 1'b1; d_sb = 1'b1; d_alu = ALU_ORI;  end
        6'h0E: begin d_rw = 1'b1; d_sb = 1'b1; d_alu = ALU_XORI; end
        6'h23: begin d_mr = 1'b1; d_mtr = 1'b1; d_rw = 1'b1; d_sb = 1'b1; end
        6'h2B: begin d_mw = 1'b1; d_sb = 1'b1; reads_rt = 1'b1; end
        default: ;
      endcase
    end
  end

  assign dec_ctrl = {d_mtr, d_rw, d_mw, d_mr, d_sa, d_sb, d_rd, d_j, d_jr, d_br};

  // ctrl_q[6] is the registered MemRead of the instruction now in EX.
  assign hazard  = (LOAD_USE_EN != 0) && (state_q == S_RUN) && id_valid_q && ctrl_q[6] &&
                   (id_rt != 5'd0) && avail &&
                   ((id_rt == head_rs) || (reads_rt && (id_rt == head_rt)));
  assign advance = !id_valid_q || bus.ex_ready;
  assign pop     = avail && !hazard && advance && !bus.flush;
  assign bus.if_ready = !bus.flush && (!full || pop);
  assign push    = bus.if_valid && bus.if_ready;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {bus.if_instr, bus.if_pc};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      wr_ptr_q <= '0; rd_ptr_q <= '0;
      id_valid_q <= 1'b0; id_pc_q <= '0; id_instr_q <= '0; ctrl_q <= '0; alu_q <= '0;
    end else if (bus.flush) begin
      state_q <= S_RUN;
      wr_ptr_q <= '0; rd_ptr_q <= '0;
      id_valid_q <= 1'b0; id_pc_q <= '0; id_instr_q <= '0; ctrl_q <= '0; alu_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (pop) begin
        id_valid_q <= 1'b1; id_pc_q <= head_pc; id_instr_q <= head_instr;
        ctrl_q <= dec_ctrl; alu_q <= d_alu;
      end else if (advance) begin
        id_valid_q <= 1'b0; id_pc_q <= '0; id_instr_q <= '0; ctrl_q <= '0; alu_q <= '0;
      end
      if (hazard && advance)        state_q <= S_BUBBLE;
      else if (state_q == S_BUBBLE) state_q <= S_RUN;
    end
  end

  assign bus.id_valid = id_valid_q;
  assign bus.id_pc    = id_pc_q;
  assign bus.id_instr = id_instr_q;
  assign bus.ALUCode  = alu_q;
  assign {bus.MemtoReg, bus.RegWrite, bus.MemWrite, bus.MemRead, bus.ALUSrcA,
          bus.ALUSrcB, bus.RegDst, bus.J, bus.JR, bus.Branch} = ctrl_q;
endmodule
`default_nettype wire

// File: tb/tb_decode_stage_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_decode_stage_pipe: directed bench for decode_stage_pipe, with and without load-use stall
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_decode_stage_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decode_stage_pipe_if #(.INSTR_W(32), .ALU_CODE_W(5)) i1 ();
  decode_stage_pipe_if #(.INSTR_W(32), .ALU_CODE_W(5)) i0 ();

  decode_stage_pipe #(.INSTR_W(32), .ALU_CODE_W(5), .QDEPTH(2), .LOAD_USE_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(i1.master));
  decode_stage_pipe #(.INSTR_W(32), .ALU_CODE_W(5), .QDEPTH(2), .LOAD_USE_EN(0)) dut_nl (
    .clk(clk), .rst_n(rst_n), .bus(i0.master));

  localparam logic [31:0] ADDU = 32'h0022_1821, ORI  = 32'h34C5_00FF, SLL  = 32'h0008_3900,
                          LW   = 32'h8C22_0000, ADD  = 32'h0044_1820, SW2  = 32'hACC2_0004,
                          ORI2 = 32'h34C2_00FF, BEQ  = 32'h1022_0004, BLTZ = 32'h0420_0008,
                          BGEZ = 32'h0421_0008, JR   = 32'h03E0_0008, JMP  = 32'h0800_0100,
                          SW   = 32'hACC5_0004, NOP  = 32'h0000_0000;
  // Bit order: MemtoReg RegWrite MemWrite MemRead ALUSrcA ALUSrcB RegDst J JR Branch
  localparam logic [9:0] C_0  = 10'b0000000000, C_RR = 10'b0100001000, C_I  = 10'b0100010000,
                         C_SH = 10'b0100101000, C_LW = 10'b1101010000, C_SW = 10'b0010010000,
                         C_BR = 10'b0000000001, C_JR = 10'b0000000010, C_J  = 10'b0000000100;

  localparam logic [31:0] T6_INS [6] = '{NOP, BLTZ, BGEZ, JR, JMP, SW};
  localparam logic [9:0]  T6_C   [6] = '{C_0, C_BR, C_BR, C_JR, C_J, C_SW};
  localparam logic [4:0]  T6_A   [6] = '{5'd0, 5'd15, 5'd12, 5'd9, 5'd0, 5'd0};

  int n_pass = 0;
  int n_chk  = 0;

  function automatic logic [47:0] s1();
    return {i1.id_valid, i1.id_instr, i1.MemtoReg, i1.RegWrite, i1.MemWrite, i1.MemRead,
            i1.ALUSrcA, i1.ALUSrcB, i1.RegDst, i1.J, i1.JR, i1.Branch, i1.ALUCode};
  endfunction

  function automatic logic [47:0] s0();
    return {i0.id_valid, i0.id_instr, i0.MemtoReg, i0.RegWrite, i0.MemWrite, i0.MemRead,
            i0.ALUSrcA, i0.ALUSrcB, i0.RegDst, i0.J, i0.JR, i0.Branch, i0.ALUCode};
  endfunction

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Invalid slots are judged on valid/controls/ALUCode only.
  task automatic chk_id(input string tag, input logic [47:0] snap, input logic v,
                        input logic [31:0] ins, input logic [9:0] c, input logic [4:0] a);
    logic [47:0] obs;
    obs = v ? snap : {snap[47], 32'h0, snap[14:0]};
    chk(tag, obs, {v, (v ? ins : 32'h0), c, a});
  endtask

  task automatic drv(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    i1.if_valid = v; i1.if_instr = ins; i1.if_pc = pc;
    i0.if_valid = v; i0.if_instr = ins; i0.if_pc = pc;
  endtask

  task automatic ctl(input logic fl, input logic er);
    i1.flush = fl; i1.ex_ready = er;
    i0.flush = fl; i0.ex_ready = er;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drv(1'b0, 32'h0, 32'h0);
    ctl(1'b0, 1'b1);
    tick(); tick();
    chk_id("reset_id", s1(), 1'b0, 32'h0, C_0, 5'd0);
    chk("reset_pc", 48'(i1.id_pc), 48'h0);
    rst_n = 1'b1;
    tick();
    chk("reset_if_ready", 48'(i1.if_ready), 48'h1);
    chk_id("reset_idle", s1(), 1'b0, 32'h0, C_0, 5'd0);

    // Stream: one instruction per cycle, each visible one cycle after push
    drv(1'b1, ADDU, 32'h100); tick();
    chk_id("t2_addu", s1(), 1'b1, ADDU, C_RR, 5'd0);
    chk("t2_addu_pc", 48'(i1.id_pc), 48'h100);
    drv(1'b1, ORI, 32'h104); tick();
    chk_id("t2_ori", s1(), 1'b1, ORI, C_I, 5'd8);
    drv(1'b1, SLL, 32'h108); tick();
    chk_id("t2_sll", s1(), 1'b1, SLL, C_SH, 5'd16);
    chk("t2_sll_pc", 48'(i1.id_pc), 48'h108);
    drv(1'b0, 32'h0, 32'h0); tick();
    chk_id("t2_drain", s1(), 1'b0, 32'h0, C_0, 5'd0);

    // Mid-stream reset with an entry parked in the queue
    ctl(1'b0, 1'b0);
    drv(1'b1, ADDU, 32'h10C); tick();
    drv(1'b1, ORI, 32'h110); tick();
    rst_n = 1'b0; #1;
    chk_id("t1_async_rst", s1(), 1'b0, 32'h0, C_0, 5'd0);
    chk("t1_async_pc", 48'(i1.id_pc), 48'h0);
    drv(1'b0, 32'h0, 32'h0); ctl(1'b0, 1'b1); #1;
    rst_n = 1'b1;
    tick();
    chk_id("t1_after_rst", s1(), 1'b0, 32'h0, C_0, 5'd0);
    chk("t1_if_ready", 48'(i1.if_ready), 48'h1);

    // Load-use through rs
    drv(1'b1, LW, 32'h200); tick();
    chk_id("t3_lw", s1(), 1'b1, LW, C_LW, 5'd0);
    chk_id("t3_lw_nl", s0(), 1'b1, LW, C_LW, 5'd0);
    drv(1'b1, ADD, 32'h204); tick();
    chk_id("t3_bubble", s1(), 1'b0, 32'h0, C_0, 5'd0);
    chk_id("t3_nl_add", s0(), 1'b1, ADD, C_RR, 5'd0);
    drv(1'b0, 32'h0, 32'h0); tick();
    chk_id("t3_add", s1(), 1'b1, ADD, C_RR, 5'd0);
    chk("t3_add_pc", 48'(i1.id_pc), 48'h204);
    chk_id("t3_nl_idle", s0(), 1'b0, 32'h0, C_0, 5'd0);
    tick();
    chk_id("t3_idle", s1(), 1'b0, 32'h0, C_0, 5'd0);
    // Load-use through rt of a store
    drv(1'b1, LW, 32'h210); tick();
    drv(1'b1, SW2, 32'h214); tick();
    chk_id("t3_sw_bubble", s1(), 1'b0, 32'h0, C_0, 5'd0);
    chk_id("t3_nl_sw", s0(), 1'b1, SW2, C_SW, 5'd0);
    drv(1'b0, 32'h0, 32'h0); tick();
    chk_id("t3_sw", s1(), 1'b1, SW2, C_SW, 5'd0);
    tick();
    // ori writes rt=$2 but does not read it: no bubble
    drv(1'b1, LW, 32'h220); tick();
    drv(1'b1, ORI2, 32'h224); tick();
    chk_id("t3_no_hazard", s1(), 1'b1, ORI2, C_I, 5'd8);
    drv(1'b0, 32'h0, 32'h0); tick();

    // Backpressure for five cycles
    ctl(1'b0, 1'b0);
    drv(1'b1, ADDU, 32'h300); tick();
    chk_id("t4_c1", s1(), 1'b1, ADDU, C_RR, 5'd0);
    drv(1'b1, ORI, 32'h304); #1;
    chk("t4_rdy1", 48'(i1.if_ready), 48'h1);
    tick();
    chk_id("t4_c2", s1(), 1'b1, ADDU, C_RR, 5'd0);
    drv(1'b1, SLL, 32'h308); #1;
    chk("t4_rdy2", 48'(i1.if_ready), 48'h1);
    tick();
    chk_id("t4_c3", s1(), 1'b1, ADDU, C_RR, 5'd0);
    drv(1'b1, JMP, 32'h30C); #1;
    chk("t4_full", 48'(i1.if_ready), 48'h0);
    tick();
    chk_id("t4_c4", s1(), 1'b1, ADDU, C_RR, 5'd0);
    tick();
    chk_id("t4_c5", s1(), 1'b1, ADDU, C_RR, 5'd0);
    chk("t4_full2", 48'(i1.if_ready), 48'h0);
    ctl(1'b0, 1'b1); #1;
    chk("t4_rdy_pop", 48'(i1.if_ready), 48'h1);
    tick();
    chk_id("t4_ori", s1(), 1'b1, ORI, C_I, 5'd8);
    chk("t4_ori_pc", 48'(i1.id_pc), 48'h304);
    drv(1'b0, 32'h0, 32'h0); tick();
    chk_id("t4_sll", s1(), 1'b1, SLL, C_SH, 5'd16);
    tick();
    chk_id("t4_j", s1(), 1'b1, JMP, C_J, 5'd0);
    tick();
    chk_id("t4_drain", s1(), 1'b0, 32'h0, C_0, 5'd0);

    // Flush with a full queue and a concurrent beq push
    ctl(1'b0, 1'b0);
    drv(1'b1, ADDU, 32'h400); tick();
    drv(1'b1, ORI, 32'h404); tick();
    drv(1'b1, SLL, 32'h408); tick();
    chk("t5_full", 48'(i1.if_ready), 48'h0);
    ctl(1'b1, 1'b0);
    drv(1'b1, BEQ, 32'h40C); #1;
    chk("t5_flush_rdy", 48'(i1.if_ready), 48'h0);
    tick();
    chk_id("t5_flushed", s1(), 1'b0, 32'h0, C_0, 5'd0);
    ctl(1'b0, 1'b1);
    drv(1'b0, 32'h0, 32'h0); tick();
    chk_id("t5_empty", s1(), 1'b0, 32'h0, C_0, 5'd0);
    chk("t5_rdy", 48'(i1.if_ready), 48'h1);
    tick();
    chk_id("t5_no_beq", s1(), 1'b0, 32'h0, C_0, 5'd0);

    // Decode corners
    for (int k = 0; k < 6; k++) begin
      drv(1'b1, T6_INS[k], 32'h500 + 32'(k * 4));
      tick();
      chk_id($sformatf("t6_dec%0d", k), s1(), 1'b1, T6_INS[k], T6_C[k], T6_A[k]);
    end
    drv(1'b0, 32'h0, 32'h0); tick();
    chk_id("t6_drain", s1(), 1'b0, 32'h0, C_0, 5'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
